dec_3x8_hold: RTL and testbench

//   Sequential 3-to-8 decoder: the output side of the 8-to-3 priority-encoder path.
//   - Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
//   - Replays each code as a one-hot 8-bit word on Y, held for a programmable number of cycles.
//   - Sits downstream of PriEncoder_3X8 and drives per-line strobes/LEDs.

---
 rtl/dec_3x8_hold_if.sv | 32 +++
 rtl/dec_3x8_hold.sv | 105 ++++++++++
 tb/tb_dec_3x8_hold.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_3x8_hold_if.sv
// Code-in / one-hot-out bus for dec_3x8_hold.
// OVF_CNT exists only when DEC_OVF_CNT_EN is defined.
interface dec_3x8_hold_if #(
  parameter int HOLD_W = 4
);
  logic [2:0]        D;
  logic              V;
  logic              RDY;
  logic [HOLD_W-1:0] HOLD;
  logic [7:0]        Y;
  logic              YV;
  logic              BUSY;
`ifdef DEC_OVF_CNT_EN
  logic [7:0]        OVF_CNT;
`endif

  modport master (
    output D, V, HOLD,
    input  RDY, Y, YV, BUSY
`ifdef DEC_OVF_CNT_EN
    , input OVF_CNT
`endif
  );

  modport slave (
    input  D, V, HOLD,
    output RDY, Y, YV, BUSY
`ifdef DEC_OVF_CNT_EN
    , output OVF_CNT
`endif
  );
endinterface

// File: rtl/dec_3x8_hold.sv
// Sequential 3-to-8 decoder: FIFO-buffered codes replayed as one-hot words held HOLD+1 cycles.
// Optional drop counter OVF_CNT is enabled by defining DEC_OVF_CNT_EN.
module dec_3x8_hold #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input logic           clk,
  input logic           rst,
  dec_3x8_hold_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  logic [2:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  state_t            state;
  logic [HOLD_W-1:0] cnt;
  logic [7:0]        y_q;
  logic              yv_q;

  logic       full, fifo_ne, push, pop;
  logic [2:0] head;

  // Ready comes from the count at the start of the cycle, so a same-edge pop
  // never makes room for a push while full.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign fifo_ne = (count != '0);
  assign push    = bus.V && !full;
  assign pop     = fifo_ne && ((state == IDLE) || (cnt == '0));
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.D;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      y_q   <= 8'h00;
      yv_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            y_q   <= 8'h01 << head;
            yv_q  <= 1'b1;
            cnt   <= bus.HOLD;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - HOLD_W'(1);
          end else if (pop) begin
            // Back-to-back replay: the next code replaces this one with no idle gap.
            y_q <= 8'h01 << head;
            cnt <= bus.HOLD;
          end else begin
            y_q   <= 8'h00;
            yv_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Y    = y_q;
  assign bus.YV   = yv_q;
  assign bus.RDY  = !full;
  assign bus.BUSY = fifo_ne || yv_q;

`ifdef DEC_OVF_CNT_EN
  logic [7:0] ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   ovf_q <= 8'h00;
    else if (bus.V && full && ovf_q != 8'hFF)  ovf_q <= ovf_q + 8'h01;
  end

  assign bus.OVF_CNT = ovf_q;
`endif
endmodule

// File: tb/tb_dec_3x8_hold.sv
// Bench for dec_3x8_hold: queue-based reference model checked every cycle, plus directed literal checks.
module tb_dec_3x8_hold;
  localparam int DEPTH  = 4;
  localparam int HOLD_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dec_3x8_hold_if #(.HOLD_W(HOLD_W)) bus ();

  dec_3x8_hold #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending codes plus the code on show and its remaining cycles.
  int q[$];
  int cur     = 0;
  bit active  = 0;
  int remain  = 0;
  int ovf     = 0;

  task automatic model_reset();
    q.delete();
    active = 0;
    remain = 0;
    cur    = 0;
    ovf    = 0;
  endtask

  task automatic model_step();
    bit rdy;
    rdy = (q.size() < DEPTH);
    if ((!active || remain == 0) && q.size() > 0) begin
      cur    = q.pop_front();
      active = 1;
      remain = int'(bus.HOLD);
    end else if (active && remain > 0) begin
      remain--;
    end else begin
      active = 0;
    end
    if (bus.V && rdy) q.push_back(int'(bus.D));
    if (bus.V && !rdy && ovf < 255) ovf++;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    logic [7:0] ey;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ey = active ? (8'h01 << cur) : 8'h00;
        check("model_Y",    32'(bus.Y),    32'(ey));
        check("model_YV",   32'(bus.YV),   32'(active));
        check("model_RDY",  32'(bus.RDY),  32'(q.size() < DEPTH));
        check("model_BUSY", 32'(bus.BUSY), 32'(q.size() > 0 || active));
        check("onehot_inv", 32'(bus.YV),   32'(bus.Y != 8'h00));
`ifdef DEC_OVF_CNT_EN
        check("model_OVF",  32'(bus.OVF_CNT), 32'(ovf));
`endif
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  bit         rec = 0;
  logic [7:0] ys[$];

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rec) ys.push_back(bus.Y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input logic [2:0] d);
    int guard = 0;
    bus.V = 1'b0;
    while (!bus.RDY && guard < 64) begin
      cycle();
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL push_wait: RDY stayed low for %0d cycles", guard);
    end
    bus.D = d;
    bus.V = 1'b1;
    cycle();
    bus.V = 1'b0;
  endtask

  function automatic int pri_enc(input logic [7:0] y);
    for (int i = 7; i >= 0; i--) if (y[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [7:0] seq3 [10];
    logic [7:0] seq6 [5];
    int run_len, run_idx;
    logic [7:0] run_val;

    bus.D = 3'd0; bus.V = 1'b0; bus.HOLD = '0;
    #2;
    check("rst0_Y",    32'(bus.Y),    32'h00);
    check("rst0_YV",   32'(bus.YV),   32'h0);
    check("rst0_RDY",  32'(bus.RDY),  32'h1);
    check("rst0_BUSY", 32'(bus.BUSY), 32'h0);
    cycle();
    rst = 1'b0;
    idle(2);

    // Reset in the middle of a hold with two codes queued.
    bus.HOLD = 4'd5;
    bus.V = 1'b1;
    bus.D = 3'd1; cycle();
    bus.D = 3'd2; cycle();
    bus.D = 3'd3; cycle();
    bus.V = 1'b0;
    cycle();
    check("pre_rst_Y", 32'(bus.Y), 32'h02);
    #2;
    rst = 1'b1;
    #1;
    check("rst1_Y",    32'(bus.Y),    32'h00);
    check("rst1_YV",   32'(bus.YV),   32'h0);
    check("rst1_RDY",  32'(bus.RDY),  32'h1);
    check("rst1_BUSY", 32'(bus.BUSY), 32'h0);
    cycle();
    rst = 1'b0;
    idle(2);

    // HOLD=0: single code, one cycle, one-edge latency.
    bus.HOLD = 4'd0;
    bus.D = 3'd3; bus.V = 1'b1;
    cycle();
    bus.V = 1'b0;
    check("lat_N_Y",  32'(bus.Y), 32'h00);
    cycle();
    check("lat_N1_Y", 32'(bus.Y), 32'h08);
    cycle();
    check("lat_N2_Y", 32'(bus.Y), 32'h00);
    idle(2);

    // HOLD=2: three back-to-back codes, three cycles each, no gap.
    seq3 = '{8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h20, 8'h20, 8'h20, 8'h00};
    bus.HOLD = 4'd2;
    bus.V = 1'b1;
    bus.D = 3'd0; cycle();
    bus.D = 3'd7; cycle();
    check("seq3_0", 32'(bus.Y), 32'(seq3[0]));
    bus.D = 3'd5; cycle();
    bus.V = 1'b0;
    check("seq3_1", 32'(bus.Y), 32'(seq3[1]));
    for (int k = 2; k < 10; k++) begin
      cycle();
      check($sformatf("seq3_%0d", k), 32'(bus.Y), 32'(seq3[k]));
    end
    idle(2);

    // HOLD=15: five pushes fill the FIFO behind the first code; the sixth is dropped.
    bus.HOLD = 4'd15;
    bus.V = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.D = 3'(k + 1);
      cycle();
    end
    check("full_RDY",  32'(bus.RDY),  32'h0);
    check("full_Y",    32'(bus.Y),    32'h02);
    check("full_BUSY", 32'(bus.BUSY), 32'h1);
    bus.D = 3'd6;
    cycle();
    bus.V = 1'b0;
    check("drop_RDY", 32'(bus.RDY), 32'h0);
`ifdef DEC_OVF_CNT_EN
    check("drop_OVF", 32'(bus.OVF_CNT), 32'h1);
`endif
    idle(90);
    check("drain_BUSY", 32'(bus.BUSY), 32'h0);

    // HOLD=1 sweep of every code, decoded back through a priority encoder.
    bus.HOLD = 4'd1;
    ys.delete();
    rec = 1;
    for (int d = 0; d < 8; d++) push(3'(d));
    idle(24);
    rec = 0;
    run_idx = 0;
    run_len = 0;
    run_val = 8'h00;
    foreach (ys[i]) begin
      if (ys[i] != run_val) begin
        if (run_val != 8'h00) begin
          check($sformatf("sweep_len_%0d", run_idx), 32'(run_len), 32'd2);
          check($sformatf("sweep_dec_%0d", run_idx), 32'(pri_enc(run_val)), 32'(run_idx));
          run_idx++;
        end
        run_val = ys[i];
        run_len = 1;
      end else begin
        run_len++;
      end
    end
    check("sweep_runs", 32'(run_idx), 32'd8);
    idle(2);

    // HOLD change 3->0 during the second hold cycle leaves the current code at 4 cycles.
    seq6 = '{8'h04, 8'h04, 8'h04, 8'h40, 8'h00};
    bus.HOLD = 4'd3;
    bus.V = 1'b1;
    bus.D = 3'd2; cycle();
    bus.D = 3'd6; cycle();
    bus.V = 1'b0;
    check("hold_chg_c1", 32'(bus.Y), 32'h04);
    cycle();
    bus.HOLD = 4'd0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold_chg_%0d", k), 32'(bus.Y), 32'(seq6[k]));
      cycle();
    end
    check("hold_chg_end", 32'(bus.BUSY), 32'h0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
